text_pixel_gen: RTL and testbench

TEXT_PIXEL_GEN -- requirements
Module: text_pixel_gen

---
 rtl/text_pixel_gen.sv | 151 +++++++++++++++
 tb/tb_text_pixel_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_pixel_gen.sv
// text_pixel_gen: character-cell text renderer front end.
//   Turns a pixel coordinate stream into text RAM / font ROM reads and emits
//   a foreground flag plus color index a fixed 4 clocks after each sample.
//   Sample edge S registers text_addr; the text RAM answers one cycle later,
//   so font_addr is registered at S+2; the font ROM answers one cycle later,
//   so ch_on/color are registered at S+4. One pixel per clock, no stalls.
// Ports:
//   Clk, Reset          clock, async active-high reset
//   DrawX, DrawY        pixel coordinate (visible 640x480)
//   pix_en              pixel request valid this cycle
//   frame_start         one-cycle pulse per frame, drives the blink timer
//   cursor_en/_x/_y     underline cursor enable and cell position
//   text_addr/text_data text RAM cell address / cell word
//                       (word: [6:0] code, [7] invert, [10:8] color, [11] blink)
//   font_addr/font_data font ROM address {code, glyph row} / glyph row bits
//   ch_on, color        foreground flag and color index to the color table
module text_pixel_gen #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pix_en,
  input  logic        frame_start,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic [11:0] text_addr,
  input  logic [11:0] text_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        ch_on,
  output logic [2:0]  color
);

  localparam int STAGES = 4;

  // sample-stage decode
  logic       vis_s;
  logic [6:0] col_s;
  logic [4:0] row_s;
  logic [3:0] grow_s;
  logic [2:0] gcol_s;
  logic       hit_s;

  // per-pixel side info, index i is aligned with edge S+i
  logic [STAGES-1:0]      vld_pipe_d,   vld_pipe_q;
  logic [STAGES-1:0]      phase_pipe_d, phase_pipe_q;
  logic [STAGES-1:0]      curs_pipe_d,  curs_pipe_q;
  logic [STAGES-1:0][2:0] gcol_pipe_d,  gcol_pipe_q;
  // glyph row only needed until font_addr is formed at S+2
  logic [1:0][3:0]        grow_pipe_d,  grow_pipe_q;
  // text_data[11:7] captured at S+2 ([0]) and S+3 ([1])
  logic [1:0][4:0]        attr_pipe_d,  attr_pipe_q;

  logic [11:0] text_addr_d, text_addr_q;
  logic [10:0] font_addr_d, font_addr_q;
  logic        ch_on_d, ch_on_q;
  logic [2:0]  color_d, color_q;
  logic [5:0]  fcnt_d, fcnt_q;
  logic        phase_d, phase_q;

  logic [4:0]  attr_o;
  logic        glyph_bit;
  logic        pix;

  always_comb begin
    vis_s  = pix_en && (DrawX < 10'd640) && (DrawY < 10'd480);
    col_s  = DrawX[9:3];
    row_s  = DrawY[8:4];
    grow_s = DrawY[3:0];
    gcol_s = DrawX[2:0];
    // Cursor is an underline on glyph rows 14/15, shown only in the "on"
    // blink half; an off-screen cursor position never matches.
    hit_s  = cursor_en && phase_q &&
             (col_s == cursor_x) && (row_s == cursor_y) &&
             (32'(cursor_x) < COLS) && (32'(cursor_y) < ROWS) &&
             (grow_s[3:1] == 3'b111);

    text_addr_d = vis_s ? 12'(32'(row_s) * COLS + 32'(col_s)) : '0;

    // phase_q is sampled before its own update, so a pixel on the
    // frame_start edge sees the old phase
    vld_pipe_d   = {vld_pipe_q[STAGES-2:0],   vis_s};
    phase_pipe_d = {phase_pipe_q[STAGES-2:0], phase_q};
    curs_pipe_d  = {curs_pipe_q[STAGES-2:0],  hit_s};
    gcol_pipe_d  = {gcol_pipe_q[STAGES-2:0],  gcol_s};
    grow_pipe_d  = {grow_pipe_q[0], grow_s};
    attr_pipe_d  = {attr_pipe_q[0], text_data[11:7]};

    font_addr_d = vld_pipe_q[1] ? {text_data[6:0], grow_pipe_q[1]} : '0;

    // output stage: font_data belongs to the pixel at index 3
    attr_o    = attr_pipe_q[1];
    glyph_bit = font_data[3'd7 - gcol_pipe_q[3]];
    if (attr_o[4] && phase_pipe_q[3]) glyph_bit = 1'b0;
    pix       = (glyph_bit ^ attr_o[0]) | curs_pipe_q[3];
    ch_on_d   = vld_pipe_q[3] & pix;
    color_d   = vld_pipe_q[3] ? attr_o[3:1] : 3'd0;

    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (fcnt_q == 6'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d  = fcnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_pipe_q   <= '0;
      phase_pipe_q <= '0;
      curs_pipe_q  <= '0;
      gcol_pipe_q  <= '0;
      grow_pipe_q  <= '0;
      attr_pipe_q  <= '0;
      text_addr_q  <= '0;
      font_addr_q  <= '0;
      ch_on_q      <= 1'b0;
      color_q      <= '0;
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
    end else begin
      vld_pipe_q   <= vld_pipe_d;
      phase_pipe_q <= phase_pipe_d;
      curs_pipe_q  <= curs_pipe_d;
      gcol_pipe_q  <= gcol_pipe_d;
      grow_pipe_q  <= grow_pipe_d;
      attr_pipe_q  <= attr_pipe_d;
      text_addr_q  <= text_addr_d;
      font_addr_q  <= font_addr_d;
      ch_on_q      <= ch_on_d;
      color_q      <= color_d;
      fcnt_q       <= fcnt_d;
      phase_q      <= phase_d;
    end
  end

  assign text_addr = text_addr_q;
  assign font_addr = font_addr_q;
  assign ch_on     = ch_on_q;
  assign color     = color_q;

endmodule

// File: tb/tb_text_pixel_gen.sv
// Bench for text_pixel_gen: synchronous 1-cycle text RAM / font ROM models,
// a per-edge behavioural reference of what each sampled pixel must produce,
// a per-cycle compare process, and directed literal cases.
module tb_text_pixel_gen;
  localparam int MAXC = 8192;

  logic        Clk = 0, Reset = 0;
  logic [9:0]  DrawX = 0, DrawY = 0;
  logic        pix_en = 0, frame_start = 0, cursor_en = 0;
  logic [6:0]  cursor_x = 0;
  logic [4:0]  cursor_y = 0;
  logic [11:0] text_addr, text_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        ch_on;
  logic [2:0]  color;

  logic [11:0] text_mem [0:2399];
  logic [7:0]  font_mem [0:2047];

  int checks = 0, errors = 0;
  int exp_ta [MAXC];
  int exp_fa [MAXC];
  int exp_ch [MAXC];
  int exp_co [MAXC];
  int ecnt = 0;
  int npulse = 0;

  text_pixel_gen dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .pix_en(pix_en), .frame_start(frame_start), .cursor_en(cursor_en),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .text_addr(text_addr),
    .text_data(text_data), .font_addr(font_addr), .font_data(font_data),
    .ch_on(ch_on), .color(color)
  );

  always #5 Clk = ~Clk;

  // memories answer one cycle after the address is presented
  always @(posedge Clk) begin
    text_data <= text_mem[text_addr];
    font_data <= font_mem[font_addr];
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // What one pixel must turn into, straight from the cell/glyph rules.
  function automatic void model(input int x, input int y, input bit en,
                                input bit ph, input bit ce, input int cx,
                                input int cy, output int ta, output int fa,
                                output int ch, output int co);
    int col, row, gr, gc, td, fd, g, p;
    ta = 0; fa = 0; ch = 0; co = 0;
    if (!(en && x < 640 && y < 480)) return;
    col = x / 8; row = y / 16; gr = y % 16; gc = x % 8;
    ta = row * 80 + col;
    td = int'(text_mem[12'(ta)]);
    fa = (td % 128) * 16 + gr;
    fd = int'(font_mem[11'(fa)]);
    g  = (fd >> (7 - gc)) & 1;
    if (((td >> 11) & 1) == 1 && ph) g = 0;
    p  = g ^ ((td >> 7) & 1);
    if (ce && ph && col == cx && row == cy && gr >= 14) p = 1;
    ch = p;
    co = (td >> 8) & 7;
  endfunction

  function automatic int getv(input int which, input int k);
    if (k < 0 || k >= MAXC) return 0;
    case (which)
      0: return exp_ta[k];
      1: return exp_fa[k];
      2: return exp_ch[k];
      default: return exp_co[k];
    endcase
  endfunction

  // reference: one entry per clock edge, phase from total pulses since reset
  initial forever begin
    int ta, fa, ch, co;
    bit ph;
    @(posedge Clk);
    ph = ((npulse / 30) % 2) == 1;
    ta = 0; fa = 0; ch = 0; co = 0;
    if (Reset) npulse = 0;
    else begin
      model(int'(DrawX), int'(DrawY), pix_en, ph, cursor_en,
            int'(cursor_x), int'(cursor_y), ta, fa, ch, co);
      if (frame_start) npulse++;
    end
    if (ecnt < MAXC) begin
      exp_ta[ecnt] = ta; exp_fa[ecnt] = fa; exp_ch[ecnt] = ch; exp_co[ecnt] = co;
    end
    ecnt++;
  end

  // async reset discards everything already sampled
  initial forever begin
    @(posedge Reset);
    for (int i = 0; i < ecnt && i < MAXC; i++) begin
      exp_ta[i] = 0; exp_fa[i] = 0; exp_ch[i] = 0; exp_co[i] = 0;
    end
    npulse = 0;
  end

  // per-cycle compare: text_addr at S, font_addr at S+2, ch_on/color at S+4
  initial forever begin
    int k;
    @(negedge Clk);
    k = ecnt - 1;
    chk("text_addr", int'(text_addr), getv(0, k));
    chk("font_addr", int'(font_addr), getv(1, k - 2));
    chk("ch_on",     int'(ch_on),     getv(2, k - 4));
    chk("color",     int'(color),     getv(3, k - 4));
  end

  task automatic drive(input int x, input int y, input bit en, input bit fs);
    DrawX = 10'(x); DrawY = 10'(y); pix_en = en; frame_start = fs;
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2400; i++) text_mem[i] = 12'($urandom);
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
    #2 Reset = 1;
    repeat (2) @(negedge Clk);
    chk("reset ch_on", int'(ch_on), 0);
    chk("reset color", int'(color), 0);
    chk("reset text_addr", int'(text_addr), 0);
    chk("reset font_addr", int'(font_addr), 0);
    #2 Reset = 0;
    idle(2);

    // 'A' at cell 0, color 3
    text_mem[0] = 12'h341; font_mem[11'h410] = 8'h80;
    drive(0, 0, 1'b1, 1'b0);
    chk("A text_addr", int'(text_addr), 0);
    idle(2);
    chk("A font_addr", int'(font_addr), 'h410);
    idle(2);
    chk("A ch_on", int'(ch_on), 1);
    chk("A color", int'(color), 3);

    // bottom-right corner and first non-visible column
    text_mem[2399] = 12'h155;
    drive(639, 479, 1'b1, 1'b0);
    chk("corner text_addr", int'(text_addr), 2399);
    idle(2);
    chk("corner font_addr", int'(font_addr), 'h55F);
    drive(640, 479, 1'b1, 1'b0);
    chk("x640 text_addr", int'(text_addr), 0);
    idle(4);
    chk("x640 ch_on", int'(ch_on), 0);
    chk("x640 color", int'(color), 0);

    // inverted blank glyph, back-to-back across a whole cell
    text_mem[250] = 12'h5A2; font_mem[11'h220] = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive(80 + i, 48, 1'b1, 1'b0); else idle(1);
      if (i >= 4) begin
        chk("invert ch_on", int'(ch_on), 1);
        chk("invert color", int'(color), 5);
      end
    end

    // blink: 30 pulses -> phase 1
    text_mem[80] = 12'hA11; font_mem[11'h110] = 8'hFF;
    repeat (30) drive(0, 0, 1'b0, 1'b1);
    drive(0, 16, 1'b1, 1'b0);
    idle(4);
    chk("blink off ch_on", int'(ch_on), 0);
    chk("blink off color", int'(color), 2);

    // cursor underline at (5,2) while phase 1
    text_mem[165] = 12'h000; font_mem[14] = 8'h00; font_mem[13] = 8'h00;
    cursor_en = 1; cursor_x = 7'd5; cursor_y = 5'd2;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive(40 + i, 46, 1'b1, 1'b0); else idle(1);
      if (i >= 4) chk("cursor row14 ch_on", int'(ch_on), 1);
    end
    drive(40, 45, 1'b1, 1'b0);
    idle(4);
    chk("cursor row13 ch_on", int'(ch_on), 0);
    cursor_en = 0;

    repeat (30) drive(0, 0, 1'b0, 1'b1);
    drive(0, 16, 1'b1, 1'b0);
    idle(4);
    chk("blink on ch_on", int'(ch_on), 1);
    chk("blink on color", int'(color), 2);

    // randomized traffic, checked by the per-cycle compare
    for (int n = 0; n < 1500; n++) begin
      int x, y;
      x = int'($urandom_range(0, 700));
      y = int'($urandom_range(0, 520));
      cursor_en = 1'($urandom_range(0, 1));
      cursor_x  = ($urandom_range(0, 1) == 1) ? 7'(x / 8) : 7'($urandom_range(0, 127));
      cursor_y  = ($urandom_range(0, 1) == 1) ? 5'(y / 16) : 5'($urandom_range(0, 31));
      drive(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0);
    end
    cursor_en = 0;
    idle(5);

    // reset with the pipeline full of lit pixels
    for (int i = 0; i < 6; i++) drive(80 + i, 48, 1'b1, 1'b0);
    chk("pre-reset ch_on", int'(ch_on), 1);
    #2 Reset = 1;
    #1;
    chk("mid reset ch_on", int'(ch_on), 0);
    chk("mid reset color", int'(color), 0);
    chk("mid reset text_addr", int'(text_addr), 0);
    repeat (2) @(negedge Clk);
    #2 Reset = 0;
    for (int i = 0; i < 5; i++) begin
      drive(80 + i, 48, 1'b1, 1'b0);
      chk("post-reset latency ch_on", int'(ch_on), (i == 4) ? 1 : 0);
    end
    idle(4);
    // counter cleared: 29 pulses keep phase 0, the 30th flips it
    repeat (29) drive(0, 0, 1'b0, 1'b1);
    drive(0, 16, 1'b1, 1'b0);
    idle(4);
    chk("cleared counter 29 ch_on", int'(ch_on), 1);
    drive(0, 0, 1'b0, 1'b1);
    drive(0, 16, 1'b1, 1'b0);
    idle(4);
    chk("cleared counter 30 ch_on", int'(ch_on), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
